// File: rtl/mix_columns_seq_if.sv
// rtl/mix_columns_seq_if.sv - handshake bundle for mix_columns_seq; carries `inverse` only under INV_MIX_EN
interface mix_columns_seq_if;
    logic         inValid;
    logic         inReady;
    logic [127:0] inputData;
    logic         skipMix;
`ifdef INV_MIX_EN
    logic         inverse;
`endif
    logic         outValid;
    logic         outReady;
    logic [127:0] outputData;

`ifdef INV_MIX_EN
    modport master (output inValid, inputData, skipMix, inverse, outReady,
                    input  inReady, outValid, outputData);
    modport slave  (input  inValid, inputData, skipMix, inverse, outReady,
                    output inReady, outValid, outputData);
`else
    modport master (output inValid, inputData, skipMix, outReady,
                    input  inReady, outValid, outputData);
    modport slave  (input  inValid, inputData, skipMix, outReady,
                    output inReady, outValid, outputData);
`endif
endinterface

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential AES MixColumns, COLS_PER_CYCLE columns per clock; INV_MIX_EN adds InvMixColumns
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    mix_columns_seq_if.slave bus
);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam bit         ONE_PASS = (COLS_PER_CYCLE == 4);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadCols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mixFwd(input logic [31:0] c);
        logic [7:0] s [4];
        logic [7:0] d [4];
        for (int i = 0; i < 4; i++) begin
            s[i] = c[31-8*i -: 8];
            d[i] = xtime(s[i]);
        end
        return {d[0] ^ d[1] ^ s[1] ^ s[2] ^ s[3],
                s[0] ^ d[1] ^ d[2] ^ s[2] ^ s[3],
                s[0] ^ s[1] ^ d[2] ^ d[3] ^ s[3],
                d[0] ^ s[0] ^ s[1] ^ s[2] ^ d[3]};
    endfunction

`ifdef INV_MIX_EN
    function automatic logic [31:0] mixInv(input logic [31:0] c);
        logic [7:0] s [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[31-8*i -: 8];
            x2    = xtime(s[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT        state, stateNext;
    logic [1:0]   colCnt;
    logic [127:0] workReg;
    logic         skipReg;
`ifdef INV_MIX_EN
    logic         invReg;
    logic         useInv;
`endif
    logic         accept;
    logic         useSkip;
    logic [1:0]   grpBase;
    logic [1:0]   colIdx;
    logic [31:0]  col;
    logic [31:0]  mixed;
    logic [127:0] srcState;
    logic [127:0] workNext;

    assign bus.inReady    = (state == IDLE) || (state == DONE && bus.outReady);
    assign bus.outValid   = (state == DONE);
    assign bus.outputData = workReg;
    assign accept         = bus.inValid && bus.inReady;

    // The first group is mixed straight from inputData on the accept edge, so a
    // state spends 4/COLS_PER_CYCLE - 1 cycles in BUSY and DONE lands on time.
    always_comb begin
        srcState = (state == BUSY) ? workReg : bus.inputData;
        grpBase  = (state == BUSY) ? colCnt : 2'd0;
        useSkip  = (state == BUSY) ? skipReg : bus.skipMix;
`ifdef INV_MIX_EN
        useInv   = (state == BUSY) ? invReg : bus.inverse;
`endif
        workNext = srcState;
        colIdx   = grpBase;
        col      = '0;
        mixed    = '0;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            colIdx = grpBase + 2'(g);
            col    = srcState[127 - 32*int'(colIdx) -: 32];
`ifdef INV_MIX_EN
            if (useSkip)     mixed = col;
            else if (useInv) mixed = mixInv(col);
            else             mixed = mixFwd(col);
`else
            mixed  = useSkip ? col : mixFwd(col);
`endif
            workNext[127 - 32*int'(colIdx) -: 32] = mixed;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.inValid) stateNext = ONE_PASS ? DONE : BUSY;
            BUSY:    if (colCnt == LAST_COL) stateNext = DONE;
            DONE:    if (bus.outReady) stateNext = bus.inValid ? (ONE_PASS ? DONE : BUSY) : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            colCnt  <= 2'd0;
            workReg <= '0;
            skipReg <= 1'b0;
`ifdef INV_MIX_EN
            invReg  <= 1'b0;
`endif
        end else begin
            state <= stateNext;
            if (accept) begin
                workReg <= workNext;
                skipReg <= bus.skipMix;
`ifdef INV_MIX_EN
                invReg  <= bus.inverse;
`endif
                colCnt  <= COL_STEP;
            end else if (state == BUSY) begin
                workReg <= workNext;
                colCnt  <= colCnt + COL_STEP;
            end
        end
    end
endmodule
